// File: rtl/quad_pkg.sv
`default_nettype none
// ============================================================================
//  quad_pkg
//  Shared definitions for the quadrature velocity block: default parameter
//  values, the sampling FSM state encoding and the signed saturation helper.
//  Revision: 1.0 - initial release
// ============================================================================
package quad_pkg;

  localparam int VEL_W_DEF    = 16;
  localparam int AVG_LOG2_DEF = 2;
  localparam int PER_W_DEF    = 24;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_t;

  // Clamp a 32-bit signed value into the range of a w-bit signed number.
  // The result stays 32 bits wide so callers can compare it with the input
  // to detect that clamping took place.
  function automatic logic signed [31:0] sat_signed(input logic signed [31:0] d,
                                                    input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    logic signed [63:0] dx;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    dx = {{32{d[31]}}, d};
    if (dx > hi) return hi[31:0];
    if (dx < lo) return lo[31:0];
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/quad_vel_window.sv
`default_nettype none
// ============================================================================
//  quad_vel_window
//  Moving-average window: shift register of 2^AVG_LOG2 signed deltas with a
//  running sum and a fill counter. Flush empties the window.
//  Ports:
//    clk, reset_n : clock, asynchronous active-low reset
//    flush        : synchronous empty of taps, sum and fill
//    push         : shift din in, oldest sample drops out of the sum
//    din          : new signed delta
//    sum          : running sum of all taps (grows by AVG_LOG2 bits, cannot wrap)
//    full         : window holds 2^AVG_LOG2 valid samples
//  Revision: 1.0 - initial release
// ============================================================================
module quad_vel_window import quad_pkg::*; #(
  parameter int VEL_W    = VEL_W_DEF,
  parameter int AVG_LOG2 = AVG_LOG2_DEF
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             flush,
  input  logic                             push,
  input  logic signed [VEL_W-1:0]          din,
  output logic signed [VEL_W+AVG_LOG2-1:0] sum,
  output logic                             full
);

  localparam int                DEPTH    = 1 << AVG_LOG2;
  localparam int                SUM_W    = VEL_W + AVG_LOG2;
  localparam logic [AVG_LOG2:0] FILL_MAX = (AVG_LOG2 + 1)'(DEPTH);

  logic signed [VEL_W-1:0] taps [DEPTH];
  logic [AVG_LOG2:0]       fill;
  logic signed [SUM_W-1:0] din_ext;
  logic signed [SUM_W-1:0] old_ext;

  assign din_ext = {{AVG_LOG2{din[VEL_W-1]}}, din};
  assign old_ext = {{AVG_LOG2{taps[DEPTH-1][VEL_W-1]}}, taps[DEPTH-1]};
  assign full    = (fill == FILL_MAX);

  // Empty taps hold zero, so subtracting the oldest tap while filling is a no-op.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) taps[i] <= '0;
      sum  <= '0;
      fill <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) taps[i] <= '0;
      sum  <= '0;
      fill <= '0;
    end else if (push) begin
      taps[0] <= din;
      for (int i = 1; i < DEPTH; i++) taps[i] <= taps[i-1];
      sum <= sum + din_ext - old_ext;
      if (!full) fill <= fill + (AVG_LOG2 + 1)'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/quad_velocity.sv
`default_nettype none
// ============================================================================
//  quad_velocity
//  Samples the 32-bit quadrature position count every sample_period cycles
//  and reports the saturated signed per-period delta plus a moving average
//  over 2^AVG_LOG2 periods.
//  Ports:
//    clk, reset_n    : clock, asynchronous active-low reset
//    count           : position count (wraps modulo 2^32)
//    clear           : re-prime baseline, flush window, zero outputs
//    sample_period   : period in clk cycles, 0 disables sampling
//    velocity        : saturated delta of the last period, vel_valid strobe
//    velocity_avg    : floor(sum / 2^AVG_LOG2), avg_valid strobe
//    overflow        : sticky saturation flag, overflow_clr clears it
//  Revision: 1.0 - initial release
// ============================================================================
module quad_velocity import quad_pkg::*; #(
  parameter int VEL_W    = VEL_W_DEF,
  parameter int AVG_LOG2 = AVG_LOG2_DEF,
  parameter int PER_W    = PER_W_DEF
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [31:0]             count,
  input  logic                    clear,
  input  logic [PER_W-1:0]        sample_period,
  output logic signed [VEL_W-1:0] velocity,
  output logic                    vel_valid,
  output logic signed [VEL_W-1:0] velocity_avg,
  output logic                    avg_valid,
  output logic                    overflow,
  input  logic                    overflow_clr
);

  localparam int SUM_W = VEL_W + AVG_LOG2;

  state_t                  state, state_nxt;
  logic [PER_W-1:0]        timer;
  logic [31:0]             prev;
  logic                    tick;
  logic                    period_zero;
  logic                    load;
  logic                    do_delta;
  logic                    flush;
  logic signed [31:0]      delta;
  logic signed [31:0]      clamped;
  logic                    sat_hit;
  logic signed [SUM_W-1:0] sum;
  logic                    full;

  assign period_zero = (sample_period == '0);
  assign tick        = (state != IDLE) && (timer == '0);
  // Modulo-2^32 subtraction makes counter wrap-around transparent.
  assign delta       = count - prev;
  assign clamped     = sat_signed(delta, VEL_W);
  assign sat_hit     = do_delta && (clamped != delta);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // clear outranks a tick in the same cycle; a zero period seen at reload
  // drops back to IDLE without producing an output for that tick.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    do_delta  = 1'b0;
    flush     = 1'b0;
    if (clear) begin
      flush     = 1'b1;
      load      = 1'b1;
      state_nxt = period_zero ? IDLE : PRIME;
    end else begin
      case (state)
        IDLE: begin
          if (!period_zero) begin
            load      = 1'b1;
            state_nxt = PRIME;
          end
        end
        PRIME, RUN: begin
          if (tick) begin
            load = 1'b1;
            if (period_zero) begin
              flush     = 1'b1;
              state_nxt = IDLE;
            end else begin
              do_delta  = (state == RUN);
              state_nxt = RUN;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timer <= '0;
      prev  <= '0;
    end else begin
      if (load)              timer <= period_zero ? '0 : sample_period - PER_W'(1);
      else if (state != IDLE) timer <= timer - PER_W'(1);
      if (tick && !clear)    prev <= count;
    end
  end

  quad_vel_window #(
    .VEL_W    (VEL_W),
    .AVG_LOG2 (AVG_LOG2)
  ) u_window (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (flush),
    .push    (do_delta),
    .din     (clamped[VEL_W-1:0]),
    .sum     (sum),
    .full    (full)
  );

  // Average is taken one cycle after the window update, once the window is full.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      velocity     <= '0;
      vel_valid    <= 1'b0;
      velocity_avg <= '0;
      avg_valid    <= 1'b0;
    end else if (clear) begin
      velocity     <= '0;
      vel_valid    <= 1'b0;
      velocity_avg <= '0;
      avg_valid    <= 1'b0;
    end else begin
      vel_valid <= do_delta;
      if (do_delta) velocity <= clamped[VEL_W-1:0];
      avg_valid <= vel_valid && full;
      if (vel_valid && full) velocity_avg <= VEL_W'(sum >>> AVG_LOG2);
    end
  end

  // New saturation wins over a simultaneous clear request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)          overflow <= 1'b0;
    else if (sat_hit)      overflow <= 1'b1;
    else if (overflow_clr) overflow <= 1'b0;
  end

endmodule
`default_nettype wire

// File: tb/tb_quad_velocity.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  tb_quad_velocity
//  Directed self-checking bench for quad_velocity (VEL_W=16, AVG_LOG2=2,
//  PER_W=24). Inputs change on the falling edge, outputs are sampled there.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_quad_velocity;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic [31:0]        count = 32'd0;
  logic               clear = 1'b0;
  logic [23:0]        sample_period = 24'd0;
  logic signed [15:0] velocity;
  logic               vel_valid;
  logic signed [15:0] velocity_avg;
  logic               avg_valid;
  logic               overflow;
  logic               overflow_clr = 1'b0;

  int step = 0;
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  quad_velocity #(
    .VEL_W    (16),
    .AVG_LOG2 (2),
    .PER_W    (24)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .count         (count),
    .clear         (clear),
    .sample_period (sample_period),
    .velocity      (velocity),
    .vel_valid     (vel_valid),
    .velocity_avg  (velocity_avg),
    .avg_valid     (avg_valid),
    .overflow      (overflow),
    .overflow_clr  (overflow_clr)
  );

  task automatic step_clk();
    @(negedge clk);
    count = count + 32'(step);
  endtask

  task automatic wait_vel(input int bound, output int n);
    n = 0;
    do begin
      step_clk();
      n++;
    end while (!vel_valid && n < bound);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    step_clk();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) step_clk();
    vectors++;
    if ({velocity, velocity_avg, vel_valid, avg_valid, overflow} !== 35'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: vel=%0d avg=%0d vv=%b av=%b ovf=%b, required all 0",
               velocity, velocity_avg, vel_valid, avg_valid, overflow);
    end
    step_clk();
    reset_n = 1'b1;
  endtask

  task automatic test_steady();
    int n, nvv, k;
    step = 0;
    count = 32'd100;
    repeat (2) step_clk();
    sample_period = 24'd10;
    wait_vel(40, n);
    vectors++;
    if (!vel_valid || n != 21) begin
      miscompares++;
      $display("FAIL steady_latency: vv=%b after %0d cycles, required 1 after 21", vel_valid, n);
    end
    vectors++;
    if (velocity !== 16'sd0) begin
      miscompares++;
      $display("FAIL steady_vel: got %0d required 0", velocity);
    end
    step_clk();
    vectors++;
    if (vel_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL steady_strobe_width: vv=%b required 0", vel_valid);
    end
    nvv = 1;
    k = 0;
    while (!avg_valid && k < 60) begin
      step_clk();
      k++;
      if (vel_valid) nvv++;
    end
    vectors++;
    if (!avg_valid || nvv != 4) begin
      miscompares++;
      $display("FAIL steady_avg_fill: av=%b after %0d strobes, required 1 after 4", avg_valid, nvv);
    end
    vectors++;
    if (velocity_avg !== 16'sd0) begin
      miscompares++;
      $display("FAIL steady_avg: got %0d required 0", velocity_avg);
    end
  endtask

  task automatic test_ramp();
    int n;
    step = 3;
    pulse_clear();
    for (int i = 0; i < 6; i++) begin
      wait_vel(25, n);
      vectors++;
      if (!vel_valid || velocity !== 16'sd30) begin
        miscompares++;
        $display("FAIL ramp_vel[%0d]: vv=%b vel=%0d required 1/30", i, vel_valid, velocity);
      end
      if (i >= 3) begin
        step_clk();
        vectors++;
        if (!avg_valid || velocity_avg !== 16'sd30) begin
          miscompares++;
          $display("FAIL ramp_avg[%0d]: av=%b avg=%0d required 1/30", i, avg_valid, velocity_avg);
        end
      end
    end
  endtask

  task automatic test_clear_on_tick();
    int n;
    wait_vel(15, n);
    repeat (9) step_clk();
    clear = 1'b1;
    step_clk();
    clear = 1'b0;
    vectors++;
    if ({vel_valid, avg_valid, velocity, velocity_avg} !== 34'd0) begin
      miscompares++;
      $display("FAIL clear_tick_outputs: vv=%b av=%b vel=%0d avg=%0d required all 0",
               vel_valid, avg_valid, velocity, velocity_avg);
    end
    wait_vel(30, n);
    vectors++;
    if (!vel_valid || n != 20) begin
      miscompares++;
      $display("FAIL clear_reprime_latency: vv=%b after %0d cycles, required 1 after 20", vel_valid, n);
    end
    vectors++;
    if (velocity !== 16'sd30) begin
      miscompares++;
      $display("FAIL clear_reprime_vel: got %0d required 30", velocity);
    end
  endtask

  task automatic test_wrap();
    int n;
    step = 0;
    count = 32'hFFFF_FFF0;
    pulse_clear();
    repeat (14) step_clk();
    count = 32'h0000_0010;
    wait_vel(12, n);
    vectors++;
    if (!vel_valid || velocity !== 16'sd32) begin
      miscompares++;
      $display("FAIL wrap_vel: vv=%b vel=%0d required 1/32", vel_valid, velocity);
    end
    vectors++;
    if (overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap_overflow: got %b required 0", overflow);
    end
  endtask

  task automatic test_saturation();
    int n;
    step = 0;
    count = 32'd0;
    pulse_clear();
    repeat (14) step_clk();
    count = 32'd40000;
    wait_vel(12, n);
    vectors++;
    if (!vel_valid || velocity !== 16'h7FFF || overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL sat_pos: vv=%b vel=%0d ovf=%b required 1/32767/1", vel_valid, velocity, overflow);
    end
    repeat (3) step_clk();
    vectors++;
    if (overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL sat_sticky: got %b required 1", overflow);
    end
    overflow_clr = 1'b1;
    step_clk();
    overflow_clr = 1'b0;
    vectors++;
    if (overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL sat_clr: got %b required 0", overflow);
    end
    count = 32'd0;
    wait_vel(12, n);
    vectors++;
    if (!vel_valid || velocity !== 16'h8000 || overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL sat_neg: vv=%b vel=%0d ovf=%b required 1/-32768/1", vel_valid, velocity, overflow);
    end
    overflow_clr = 1'b1;
    count = 32'd40000;
    wait_vel(12, n);
    vectors++;
    if (!vel_valid || overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL sat_set_wins: vv=%b ovf=%b required 1/1", vel_valid, overflow);
    end
    step_clk();
    overflow_clr = 1'b0;
    vectors++;
    if (overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL sat_clr_after: got %b required 0", overflow);
    end
  endtask

  task automatic test_floor_avg();
    int n;
    int cnt_tab [4] = '{995, 989, 984, 978};
    int vel_tab [4] = '{-5, -6, -5, -6};
    step = 0;
    count = 32'd1000;
    pulse_clear();
    repeat (14) step_clk();
    for (int k = 0; k < 4; k++) begin
      count = 32'(cnt_tab[k]);
      wait_vel(12, n);
      vectors++;
      if (!vel_valid || velocity !== 16'(vel_tab[k])) begin
        miscompares++;
        $display("FAIL floor_vel[%0d]: vv=%b vel=%0d required 1/%0d", k, vel_valid, velocity, vel_tab[k]);
      end
      if (k < 3) repeat (5) step_clk();
    end
    step_clk();
    vectors++;
    if (!avg_valid || velocity_avg !== -16'sd6) begin
      miscompares++;
      $display("FAIL floor_avg: av=%b avg=%0d required 1/-6", avg_valid, velocity_avg);
    end
  endtask

  task automatic test_disable();
    int n, strobes;
    sample_period = 24'd0;
    strobes = 0;
    for (int i = 0; i < 40; i++) begin
      step_clk();
      if (vel_valid || avg_valid) strobes++;
    end
    vectors++;
    if (strobes != 0) begin
      miscompares++;
      $display("FAIL disable_strobes: got %0d required 0", strobes);
    end
    vectors++;
    if (velocity !== -16'sd6 || velocity_avg !== -16'sd6) begin
      miscompares++;
      $display("FAIL disable_hold: vel=%0d avg=%0d required -6/-6", velocity, velocity_avg);
    end
    step = 3;
    sample_period = 24'd10;
    wait_vel(40, n);
    vectors++;
    if (!vel_valid || n != 21 || velocity !== 16'sd30) begin
      miscompares++;
      $display("FAIL disable_restart: vv=%b n=%0d vel=%0d required 1/21/30", vel_valid, n, velocity);
    end
  endtask

  task automatic test_async_reset();
    int n;
    repeat (3) step_clk();
    #2 reset_n = 1'b0;
    #1;
    vectors++;
    if ({velocity, velocity_avg, vel_valid, avg_valid, overflow} !== 35'd0) begin
      miscompares++;
      $display("FAIL async_reset: vel=%0d avg=%0d vv=%b av=%b ovf=%b required all 0",
               velocity, velocity_avg, vel_valid, avg_valid, overflow);
    end
    step_clk();
    reset_n = 1'b1;
    wait_vel(40, n);
    vectors++;
    if (!vel_valid || n != 21 || velocity !== 16'sd30) begin
      miscompares++;
      $display("FAIL async_restart: vv=%b n=%0d vel=%0d required 1/21/30", vel_valid, n, velocity);
    end
  endtask

  initial begin
    test_reset();
    test_steady();
    test_ramp();
    test_clear_on_tick();
    test_wrap();
    test_saturation();
    test_floor_avg();
    test_disable();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
